// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode-side control, instruction-memory handshake and held-instruction outputs.
// The master modport is the fetch stage itself; the slave modport is its environment.
interface fetch_stage_if;
  logic        Stall;
  logic        Flush;
  logic [63:0] BranchTarget;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic [31:0] IMemRdata;
  logic        IMemAck;
  logic [63:0] IF_PC;
  logic [31:0] IF_Instr;
  logic [6:0]  OPCode;
  logic [3:0]  Funct;
  logic        IF_Valid;

  modport master (
    input  Stall, Flush, BranchTarget, IMemRdata, IMemAck,
    output IMemReq, IMemAddr, IF_PC, IF_Instr, OPCode, Funct, IF_Valid
  );

  modport slave (
    output Stall, Flush, BranchTarget, IMemRdata, IMemAck,
    input  IMemReq, IMemAddr, IF_PC, IF_Instr, OPCode, Funct, IF_Valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with a one-entry skid; an ack at edge N is visible after edge N (1 cycle).
// Stall freezes a live output; an ack that cannot land goes to the skid and requests pause (HOLD).
module fetch_stage (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [31:0] skid_instr;
  logic [63:0] skid_pc;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        imem_req;
  logic        out_free;

  assign out_free     = !if_valid || !bus.Stall;

  assign bus.IMemReq  = imem_req;
  assign bus.IMemAddr = pc;
  assign bus.IF_PC    = if_pc;
  assign bus.IF_Instr = if_instr;
  assign bus.IF_Valid = if_valid;
  assign bus.OPCode   = if_instr[6:0];
  assign bus.Funct    = {if_instr[30], if_instr[14:12]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pc         <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      if_pc      <= '0;
      if_instr   <= '0;
      if_valid   <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (bus.Flush) pc <= bus.BranchTarget;
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (bus.Flush) begin
            pc       <= bus.BranchTarget;
            if_valid <= 1'b0;
          end else if (bus.IMemAck) begin
            pc <= pc + 64'd4;
            if (out_free) begin
              if_instr <= bus.IMemRdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
            end else begin
              // Decode is stalled on a live instruction: park the word and pause requests.
              skid_instr <= bus.IMemRdata;
              skid_pc    <= pc;
              state      <= HOLD;
              imem_req   <= 1'b0;
            end
          end else if (!bus.Stall) begin
            if_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (bus.Flush) begin
            pc         <= bus.BranchTarget;
            if_valid   <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            state      <= REQ;
            imem_req   <= 1'b1;
          end else if (!bus.Stall) begin
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            if_valid <= 1'b1;
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: q[0] is the instruction on the outputs, q[1] the one parked behind it.
  ent_t        q[$];
  logic [63:0] m_pc;
  logic [63:0] d_pc;
  logic [31:0] d_instr;
  bit          m_boot;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = '0;
    d_pc    = '0;
    d_instr = '0;
    m_boot  = 1'b1;
  endtask

  task automatic model_step(input bit stall, input bit flush, input logic [63:0] bt,
                            input bit ack, input logic [31:0] rdata);
    bit take;
    if (m_boot) begin
      m_boot = 1'b0;
      if (flush) m_pc = bt;
    end else if (flush) begin
      q.delete();
      m_pc = bt;
    end else begin
      take = ack && (q.size() < 2);
      if (!stall && q.size() > 0) void'(q.pop_front());
      if (take) begin
        q.push_back('{m_pc, rdata});
        m_pc = m_pc + 64'd4;
      end
      if (q.size() > 0) begin
        d_pc    = q[0].pc;
        d_instr = q[0].instr;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ins;
    ins = d_instr;
    chk({tag, ".valid"}, 64'(bus.IF_Valid), 64'(q.size() > 0));
    chk({tag, ".req"},   64'(bus.IMemReq),  64'(!m_boot && q.size() < 2));
    chk({tag, ".addr"},  bus.IMemAddr, m_pc);
    chk({tag, ".pc"},    bus.IF_PC, d_pc);
    chk({tag, ".instr"}, 64'(bus.IF_Instr), 64'(ins));
    chk({tag, ".opc"},   64'(bus.OPCode), 64'(ins[6:0]));
    chk({tag, ".funct"}, 64'(bus.Funct), 64'({ins[30], ins[14:12]}));
  endtask

  task automatic cycle(input string tag, input bit stall, input bit flush, input logic [63:0] bt,
                       input bit ack, input logic [31:0] rdata);
    bus.Stall        = stall;
    bus.Flush        = flush;
    bus.BranchTarget = bt;
    bus.IMemAck      = ack;
    bus.IMemRdata    = rdata;
    @(posedge clk);
    model_step(stall, flush, bt, ack, rdata);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asserts reset away from any edge, checks outputs clear immediately, then releases.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, 64'(bus.IF_Valid), 64'd0);
    chk({tag, ".rst_req"},   64'(bus.IMemReq),  64'd0);
    chk({tag, ".rst_addr"},  bus.IMemAddr, 64'd0);
    chk({tag, ".rst_pc"},    bus.IF_PC, 64'd0);
    chk({tag, ".rst_instr"}, 64'(bus.IF_Instr), 64'd0);
    chk({tag, ".rst_opc"},   64'(bus.OPCode), 64'd0);
    chk({tag, ".rst_funct"}, 64'(bus.Funct), 64'd0);
    model_reset();
    bus.IMemAck   = 1'b1;
    bus.IMemRdata = $urandom;
    bus.Stall     = 1'b0;
    bus.Flush     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all({tag, ".boot"});
  endtask

  initial begin
    bus.Stall        = 1'b0;
    bus.Flush        = 1'b0;
    bus.BranchTarget = '0;
    bus.IMemAck      = 1'b0;
    bus.IMemRdata    = '0;

    // First fetch with the ack tied high.
    do_reset("s1");
    cycle("s1.c0", 0, 0, 64'h0, 1, 32'h00002083);
    chk("s1.req_after_boot", 64'(bus.IMemReq), 64'd1);
    chk("s1.addr0", bus.IMemAddr, 64'h0);
    cycle("s1.c1", 0, 0, 64'h0, 1, 32'h00002083);
    chk("s1.valid", 64'(bus.IF_Valid), 64'd1);
    chk("s1.pc", bus.IF_PC, 64'h0);
    chk("s1.opc", 64'(bus.OPCode), 64'b0000011);
    chk("s1.funct", 64'(bus.Funct), 64'b0010);

    // Back-to-back acks.
    do_reset("s2");
    cycle("s2.boot", 0, 0, 64'h0, 0, 32'h0);
    cycle("s2.a0", 0, 0, 64'h0, 1, 32'h002081B3);
    chk("s2.opc0", 64'(bus.OPCode), 64'b0110011);
    chk("s2.funct0", 64'(bus.Funct), 64'b0000);
    chk("s2.pc0", bus.IF_PC, 64'h0);
    cycle("s2.a1", 0, 0, 64'h0, 1, 32'h402081B3);
    chk("s2.opc1", 64'(bus.OPCode), 64'b0110011);
    chk("s2.funct1", 64'(bus.Funct), 64'b1000);
    chk("s2.pc1", bus.IF_PC, 64'h4);
    chk("s2.addr", bus.IMemAddr, 64'h8);

    // Stall while the PC=4 ack arrives, then release.
    do_reset("s3");
    cycle("s3.boot", 0, 0, 64'h0, 0, 32'h0);
    cycle("s3.a0", 0, 0, 64'h0, 1, 32'h11111113);
    cycle("s3.hold", 1, 0, 64'h0, 1, 32'h22222213);
    chk("s3.hold_req", 64'(bus.IMemReq), 64'd0);
    chk("s3.hold_pc", bus.IF_PC, 64'h0);
    cycle("s3.rel", 0, 0, 64'h0, 1, 32'h33333313);
    chk("s3.rel_pc", bus.IF_PC, 64'h4);
    chk("s3.rel_instr", 64'(bus.IF_Instr), 64'h22222213);
    chk("s3.rel_addr", bus.IMemAddr, 64'h8);
    chk("s3.rel_req", 64'(bus.IMemReq), 64'd1);

    // Flush with a simultaneous ack.
    cycle("s4.flush", 0, 1, 64'h100, 1, 32'h44444413);
    chk("s4.valid", 64'(bus.IF_Valid), 64'd0);
    chk("s4.addr", bus.IMemAddr, 64'h100);
    cycle("s4.next", 0, 0, 64'h0, 1, 32'h55555513);
    chk("s4.pc", bus.IF_PC, 64'h100);

    // Flush while holding a skid entry.
    cycle("s5.hold", 1, 0, 64'h0, 1, 32'h66666613);
    chk("s5.hold_req", 64'(bus.IMemReq), 64'd0);
    cycle("s5.flush", 1, 1, 64'h2000, 0, 32'h0);
    chk("s5.valid", 64'(bus.IF_Valid), 64'd0);
    chk("s5.addr", bus.IMemAddr, 64'h2000);
    cycle("s5.idle", 0, 0, 64'h0, 0, 32'h0);
    chk("s5.skid_gone", 64'(bus.IF_Valid), 64'd0);

    // Asynchronous reset in REQ with PC=0x0C.
    do_reset("s6");
    cycle("s6.boot", 0, 0, 64'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle("s6.fill", 0, 0, 64'h0, 1, $urandom);
    chk("s6.pc_c", bus.IMemAddr, 64'hC);
    do_reset("s6r");
    chk("s6.boot_req", 64'(bus.IMemReq), 64'd0);
    cycle("s6.boot2", 0, 0, 64'h0, 1, 32'h00002083);
    chk("s6.restart_addr", bus.IMemAddr, 64'h0);
    cycle("s6.first", 0, 0, 64'h0, 1, 32'h00002083);
    chk("s6.first_pc", bus.IF_PC, 64'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset("rnd");
      end else begin
        cycle("rnd",
              $urandom_range(99) < 35,
              $urandom_range(99) < 5,
              {$urandom, $urandom},
              $urandom_range(99) < 65,
              $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
